// File: rtl/color_preset_memory.sv
// Colour preset store: DEPTH x WIDTH register file with a registered read port
// and a looping playback sequencer that holds each entry for dwell+1 clocks.
module color_preset_memory #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_enable,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [WIDTH-1:0]   data_out,
  output logic               rd_valid,
  input  logic               play_en,
  input  logic [ADDR_W-1:0]  play_last,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   play_data,
  output logic [ADDR_W-1:0]  play_idx,
  output logic               play_wrap
);

  localparam logic [ADDR_W-1:0] LAST_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    PLAY
  } state_t;

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    mem_reg [DEPTH];
  logic [DEPTH-1:0]    wr_hit;
  logic [WIDTH-1:0]    rd_word;
  logic [WIDTH-1:0]    play_word;
  logic [ADDR_W-1:0]   last_eff;
  logic [WIDTH-1:0]    data_out_reg;
  logic                rd_valid_reg;
  logic [WIDTH-1:0]    pdata_reg, pdata_next;
  logic [ADDR_W-1:0]   idx_reg, idx_next;
  logic [DWELL_W-1:0]  count_reg, count_next;
  logic                wrap_reg, wrap_next;

  // One-hot write decode; out-of-range addresses match no entry and are dropped.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_decode
    assign wr_hit[gi] = write_enable && (wr_addr == ADDR_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_hit[i]) begin
          mem_reg[i] <= data_in;
        end
      end
    end
  end

  // Both read muxes bypass the incoming write so a same-edge hit sees data_in.
  always_comb begin
    rd_word   = '0;
    play_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_word = wr_hit[i] ? data_in : mem_reg[i];
      end
      if (idx_reg == ADDR_W'(i)) begin
        play_word = wr_hit[i] ? data_in : mem_reg[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_reg <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) begin
        data_out_reg <= rd_word;
      end
    end
  end

  assign last_eff = (play_last > LAST_MAX) ? LAST_MAX : play_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      pdata_reg <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pdata_reg <= pdata_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pdata_next = pdata_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    wrap_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        idx_next   = '0;
        count_next = '0;
        if (play_en) begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (!play_en) begin
          state_next = IDLE;
          idx_next   = '0;
          count_next = '0;
        end else begin
          pdata_next = play_word;
          if (count_reg < dwell) begin
            count_next = count_reg + 1'b1;
          end else begin
            count_next = '0;
            // >= also catches an index stranded above a freshly lowered play_last.
            if (idx_reg >= last_eff) begin
              idx_next  = '0;
              wrap_next = 1'b1;
            end else begin
              idx_next = idx_reg + 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data_out  = data_out_reg;
  assign rd_valid  = rd_valid_reg;
  assign play_data = pdata_reg;
  assign play_idx  = idx_reg;
  assign play_wrap = wrap_reg;

endmodule
